// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: command field layout and FSM state encoding for the ALU operand sequencer.
package alu_op_sequencer_pkg;
  localparam int CMD_W   = 7;
  localparam int SEL_MSB = 6;
  localparam int SEL_LSB = 5;
  localparam int CIN_BIT = 4;
  localparam int B_MSB   = 3;
  localparam int B_LSB   = 2;
  localparam int A_MSB   = 1;
  localparam int A_LSB   = 0;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// alu_cmd_fifo: show-ahead command FIFO; full/empty come from an occupancy counter.
module alu_cmd_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers host ALU commands, issues them to an external ALU one at a time
// and returns each captured result over a valid/ready channel.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CMD_W-1:0] cmd_data_i,
  output logic [1:0]       alu_a_o,
  output logic [1:0]       alu_b_o,
  output logic             alu_cin_o,
  output logic [1:0]       alu_sel_o,
  input  logic [3:0]       alu_out_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [3:0]       res_data_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] done_cnt_o
);
  state_e                      state_q, state_d;
  logic [1:0]                  a_q, a_d, b_q, b_d, sel_q, sel_d;
  logic                        cin_q, cin_d;
  logic [3:0]                  res_q, res_d;
  logic                        res_valid_q, res_valid_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        pop, full, empty;
  logic [CMD_W-1:0]            head;
  logic [$clog2(FIFO_DEPTH):0] occ;
  alu_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid_i),
    .wdata_i (cmd_data_i),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occ)
  );
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    sel_d       = sel_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) begin
        pop     = 1'b1;
        a_d     = head[A_MSB:A_LSB];
        b_d     = head[B_MSB:B_LSB];
        cin_d   = head[CIN_BIT];
        sel_d   = head[SEL_MSB:SEL_LSB];
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        res_d       = alu_out_i;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: if (res_valid_q && res_ready_i) begin
        res_valid_d = 1'b0;
        cnt_d       = cnt_q + CNT_W'(1);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sel_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      sel_q       <= sel_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
    end
  end
  assign cmd_ready_o = ~full;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_cin_o   = cin_q;
  assign alu_sel_o   = sel_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_q;
  assign done_cnt_o  = cnt_q;
  assign busy_o      = (state_q != ST_IDLE) || (occ != '0);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scenarios against a behavioural ALU stub.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_data = '0;
  logic [1:0] alu_a, alu_b, alu_sel;
  logic       alu_cin;
  logic [3:0] alu_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       busy;
  logic [7:0] done_cnt;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_data_i(cmd_data), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
    .alu_sel_o(alu_sel), .alu_out_i(alu_out), .res_valid_o(res_valid),
    .res_ready_i(res_ready), .res_data_o(res_data), .busy_o(busy), .done_cnt_o(done_cnt)
  );

  always_comb begin
    case (alu_sel)
      2'b00: alu_out = {2'b00, alu_a} + {2'b00, alu_b} + {3'b000, alu_cin};
      2'b01: alu_out = {2'b00, alu_a} - {2'b00, alu_b};
      2'b10: alu_out = {2'b00, alu_a & alu_b};
      default: alu_out = {2'b00, alu_a | alu_b};
    endcase
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [6:0] c, output bit ok);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = c;
    while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
    ok = cmd_ready;
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic get_res(output logic [3:0] d, output bit ok);
    int n = 0;
    @(negedge clk);
    res_ready = 1'b1;
    while (!res_valid && n < 40) begin @(negedge clk); n++; end
    ok = res_valid; d = res_data;
    @(posedge clk); #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ok; logic [3:0] d;
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_data = 7'b00_0_01_01;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    vecs++; if (done_cnt !== 8'd0) begin errs++; $display("FAIL rst_done_cnt got %0d want 0", done_cnt); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    vecs++; if ({alu_a, alu_b, alu_cin, alu_sel, res_data} !== 11'd0) begin errs++; $display("FAIL rst_regs got %h want 0", {alu_a, alu_b, alu_cin, alu_sel, res_data}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL first_push_busy got %b want 1", busy); end
    get_res(d, ok);
    vecs++; if (!ok || d !== 4'd2) begin errs++; $display("FAIL first_push_res got %0d (valid %b) want 2", d, ok); end
  endtask

  task automatic test_single_op();
    int edges;
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 7'b00_1_10_11; res_ready = 1'b1;
    @(posedge clk); edges = 1; #1 cmd_valid = 1'b0;
    while (!res_valid && edges < 10) begin @(posedge clk); #1; edges++; end
    vecs++; if (edges !== 3) begin errs++; $display("FAIL single_latency got %0d edges want 3", edges); end
    vecs++; if (res_data !== 4'd6) begin errs++; $display("FAIL single_res got %0d want 6", res_data); end
    @(posedge clk); #1 res_ready = 1'b0;
    vecs++; if (done_cnt !== 8'd1) begin errs++; $display("FAIL single_done_cnt got %0d want 1", done_cnt); end
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL single_valid_drop got %b want 0", res_valid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_busy got %b want 0", busy); end
    vecs++; if (res_data !== 4'd6) begin errs++; $display("FAIL single_res_keep got %0d want 6", res_data); end
  endtask

  task automatic test_backpressure();
    logic [6:0] cmds [6] = '{7'b00_0_01_01, 7'b01_0_10_01, 7'b10_0_10_11, 7'b11_0_10_01, 7'b00_1_11_11, 7'b01_0_00_11};
    logic [3:0] exp [6] = '{4'd2, 4'd15, 4'd2, 4'd3, 4'd7, 4'd3};
    bit ok; logic [3:0] d; bit stall_bad = 0;
    do_reset();
    push(cmds[0], ok);
    for (int i = 1; i < 5; i++) push(cmds[i], ok);
    vecs++; if (!ok || cmd_ready !== 1'b0) begin errs++; $display("FAIL bp_full got ready %b want 0", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = cmds[5];
    repeat (4) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== exp[0]) stall_bad = 1;
    end
    vecs++; if (stall_bad) begin errs++; $display("FAIL bp_stall got ready %b valid %b data %0d want 0 1 %0d", cmd_ready, res_valid, res_data, exp[0]); end
    cmd_valid = 1'b0;
    get_res(d, ok);
    vecs++; if (!ok || d !== exp[0]) begin errs++; $display("FAIL bp_res0 got %0d want %0d", d, exp[0]); end
    push(cmds[5], ok);
    vecs++; if (!ok) begin errs++; $display("FAIL bp_5th_push got ready 0 want accepted"); end
    for (int i = 1; i < 6; i++) begin
      get_res(d, ok);
      vecs++; if (!ok || d !== exp[i]) begin errs++; $display("FAIL bp_res%0d got %0d want %0d", i, d, exp[i]); end
    end
  endtask

  task automatic test_ordering();
    logic [6:0] cmds [3] = '{7'b11_0_10_01, 7'b10_0_01_11, 7'b00_1_11_11};
    logic [3:0] exp [3] = '{4'd3, 4'd1, 4'd7};
    bit ok; logic [3:0] d; bit extra = 0;
    do_reset();
    for (int i = 0; i < 3; i++) push(cmds[i], ok);
    for (int i = 0; i < 3; i++) begin
      get_res(d, ok);
      vecs++; if (!ok || d !== exp[i]) begin errs++; $display("FAIL ord_res%0d got %0d want %0d", i, d, exp[i]); end
    end
    repeat (6) begin @(negedge clk); if (res_valid) extra = 1; end
    vecs++; if (extra) begin errs++; $display("FAIL ord_duplicate got extra result want none"); end
    vecs++; if (done_cnt !== 8'd3) begin errs++; $display("FAIL ord_done_cnt got %0d want 3", done_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok; logic [3:0] d; int n = 0;
    do_reset();
    push(7'b00_0_01_01, ok);
    push(7'b00_1_01_01, ok);
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    vecs++; if (res_valid !== 1'b0) begin errs++; $display("FAIL ares_valid got %b want 0", res_valid); end
    vecs++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL ares_fifo got ready %b busy %b want 1 0", cmd_ready, busy); end
    vecs++; if (done_cnt !== 8'd0) begin errs++; $display("FAIL ares_done_cnt got %0d want 0", done_cnt); end
    @(negedge clk) rst_n = 1'b1;
    push(7'b00_0_01_10, ok);
    get_res(d, ok);
    vecs++; if (!ok || d !== 4'd3) begin errs++; $display("FAIL ares_after got %0d want 3", d); end
    vecs++; if (done_cnt !== 8'd1) begin errs++; $display("FAIL ares_after_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap_and_push_pop();
    bit ok; logic [3:0] d; int bad = 0; int n = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        vecs++; if (done_cnt !== 8'd255) begin errs++; $display("FAIL wrap_pre got %0d want 255", done_cnt); end
      end
      push(7'b11_0_01_10, ok);
      if (!ok) bad++;
      get_res(d, ok);
      if (!ok || d !== 4'd3) bad++;
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL wrap_ops got %0d bad ops want 0", bad); end
    vecs++; if (done_cnt !== 8'd0) begin errs++; $display("FAIL wrap_cnt got %0d want 0", done_cnt); end
    push(7'b00_0_00_01, ok);
    push(7'b01_0_01_11, ok);
    push(7'b00_1_10_10, ok);
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    vecs++; if (dut.u_fifo.count_o !== 3'd2) begin errs++; $display("FAIL pp_occ_pre got %0d want 2", dut.u_fifo.count_o); end
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 7'b01_0_11_00;
    @(posedge clk); #1 cmd_valid = 1'b0;
    vecs++; if (dut.u_fifo.count_o !== 3'd2 || alu_a !== 2'd3) begin errs++; $display("FAIL pp_occ got %0d a %0d want 2 3", dut.u_fifo.count_o, alu_a); end
    get_res(d, ok);
    vecs++; if (!ok || d !== 4'd2) begin errs++; $display("FAIL pp_res0 got %0d want 2", d); end
    get_res(d, ok);
    vecs++; if (!ok || d !== 4'd5) begin errs++; $display("FAIL pp_res1 got %0d want 5", d); end
    get_res(d, ok);
    vecs++; if (!ok || d !== 4'd13) begin errs++; $display("FAIL pp_res2 got %0d want 13", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_backpressure();
    test_ordering();
    test_async_reset();
    test_wrap_and_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
